// File: rtl/slow_counter_ctrl.sv
// Bounded, restartable slow counter: an internal prescaler produces count ticks,
// and a small FSM runs the count up to a captured limit with pause, clear and auto-reload.
module slow_counter_ctrl #(
    parameter int TICK_CYCLES = 5000,
    parameter int N           = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         clear,
    input  logic         auto_reload,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         tick,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [25:0] PRE_RELOAD = 26'(TICK_CYCLES - 1);

    state_t       state_q;
    logic [25:0]  pre;
    logic [N-1:0] limit_q;
    logic [N-1:0] nxt;

    assign nxt   = count + 1'b1;
    assign tick  = (state_q == S_RUN) && (pre == '0) && !pause && !clear;
    assign busy  = (state_q == S_RUN) || (state_q == S_PAUSED);
    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pre     <= PRE_RELOAD;
            limit_q <= '0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so any set below lasts exactly one cycle.
            done <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                count   <= '0;
                pre     <= PRE_RELOAD;
            end else begin
                unique case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            limit_q <= limit;
                            count   <= '0;
                            pre     <= PRE_RELOAD;
                            if (limit == '0) begin
                                state_q <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        // Pause wins over a coincident tick; pre is left at 0 so the
                        // suppressed tick fires on the first cycle back in RUN.
                        if (pause) begin
                            state_q <= S_PAUSED;
                        end else if (pre == '0) begin
                            pre <= PRE_RELOAD;
                            if (nxt == limit_q) begin
                                done <= 1'b1;
                                if (auto_reload) begin
                                    count <= '0;
                                end else begin
                                    count   <= limit_q;
                                    state_q <= S_DONE;
                                end
                            end else begin
                                count <= nxt;
                            end
                        end else begin
                            pre <= pre - 1'b1;
                        end
                    end
                    S_PAUSED: begin
                        if (!pause) state_q <= S_RUN;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slow_counter_ctrl.sv
// Self-checking bench for slow_counter_ctrl: directed table, hand-written corner
// sequences and randomized stimulus compared against a period-counting reference model.
module tb_slow_counter_ctrl;

    localparam int T = 4;
    localparam int N = 4;

    localparam int IDLE   = 0;
    localparam int RUN    = 1;
    localparam int PAUSED = 2;
    localparam int DONE   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         clear = 1'b0;
    logic         auto_reload = 1'b0;
    logic [N-1:0] limit = '0;
    logic [N-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    int n_checks = 0;
    int n_fail   = 0;

    // Outputs as observed in the most recent cycle applied by cyc().
    logic [N-1:0] o_count;
    logic         o_tick;
    logic         o_busy;
    logic         o_done;
    logic [1:0]   o_state;

    // Reference model: elapsed counts RUN cycles spent in the current tick period.
    int m_state;
    int m_count;
    int m_elapsed;
    int m_limit;
    int m_done;

    typedef struct {
        logic         start;
        logic         pause;
        logic         clear;
        logic         ar;
        logic [N-1:0] limit;
        logic [N-1:0] e_count;
        logic         e_tick;
        logic         e_busy;
        logic         e_done;
        logic [1:0]   e_state;
    } vec_t;

    vec_t tbl[15];

    slow_counter_ctrl #(.TICK_CYCLES(T), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .auto_reload (auto_reload),
        .limit       (limit),
        .count       (count),
        .tick        (tick),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = IDLE;
        m_count   = 0;
        m_elapsed = 0;
        m_limit   = 0;
        m_done    = 0;
    endtask

    function automatic int model_tick(input logic p, input logic c);
        return (m_state == RUN && m_elapsed == T - 1 && !p && !c) ? 1 : 0;
    endfunction

    task automatic model_step(input logic s, input logic p, input logic c,
                              input logic ar, input int lim);
        int t;
        t      = model_tick(p, c);
        m_done = 0;
        if (c) begin
            m_state   = IDLE;
            m_count   = 0;
            m_elapsed = 0;
        end else if ((m_state == IDLE || m_state == DONE) && s) begin
            m_limit   = lim;
            m_count   = 0;
            m_elapsed = 0;
            if (lim == 0) begin
                m_state = DONE;
                m_done  = 1;
            end else begin
                m_state = RUN;
            end
        end else if (m_state == RUN && p) begin
            m_state = PAUSED;
        end else if (m_state == PAUSED && !p) begin
            m_state = RUN;
        end else if (m_state == RUN) begin
            if (t != 0) begin
                m_elapsed = 0;
                if ((m_count + 1) % (1 << N) == m_limit) begin
                    m_done = 1;
                    if (ar) begin
                        m_count = 0;
                    end else begin
                        m_count = m_limit;
                        m_state = DONE;
                    end
                end else begin
                    m_count = (m_count + 1) % (1 << N);
                end
            end else begin
                m_elapsed++;
            end
        end
    endtask

    // Applies one cycle of inputs (called at a falling edge), checks against the model,
    // then advances model and DUT through the next rising edge.
    task automatic cyc(input logic s, input logic p, input logic c,
                       input logic ar, input logic [N-1:0] lim);
        start       = s;
        pause       = p;
        clear       = c;
        auto_reload = ar;
        limit       = lim;
        #1;
        o_count = count;
        o_tick  = tick;
        o_busy  = busy;
        o_done  = done;
        o_state = state;
        check("model.count", o_count, m_count);
        check("model.tick",  o_tick,  model_tick(p, c));
        check("model.busy",  o_busy,  (m_state == RUN || m_state == PAUSED) ? 1 : 0);
        check("model.done",  o_done,  m_done);
        check("model.state", o_state, m_state);
        @(posedge clk);
        model_step(s, p, c, ar, int'(lim));
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".count"}, count, 0);
        check({tag, ".tick"},  tick,  0);
        check({tag, ".busy"},  busy,  0);
        check({tag, ".done"},  done,  0);
        check({tag, ".state"}, state, IDLE);
    endtask

    // Asynchronous reset: outputs must reach reset values with no clock edge in between.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n_tick;
        int n_done;
        int n_seen;
        int pause_left;

        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Directed table: limit=3, no reload, single start pulse.
        for (int i = 0; i < 15; i++) begin
            tbl[i].start = (i == 0);
            tbl[i].pause = 1'b0;
            tbl[i].clear = 1'b0;
            tbl[i].ar    = 1'b0;
            tbl[i].limit = N'(3);
            if (i == 0) begin
                tbl[i].e_count = '0; tbl[i].e_tick = 0; tbl[i].e_busy = 0;
                tbl[i].e_done = 0;   tbl[i].e_state = 2'(IDLE);
            end else if (i <= 12) begin
                tbl[i].e_count = N'((i - 1) / T); tbl[i].e_tick = (i % T == 0);
                tbl[i].e_busy = 1; tbl[i].e_done = 0; tbl[i].e_state = 2'(RUN);
            end else begin
                tbl[i].e_count = N'(3); tbl[i].e_tick = 0; tbl[i].e_busy = 0;
                tbl[i].e_done = (i == 13); tbl[i].e_state = 2'(DONE);
            end
        end
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].start, tbl[i].pause, tbl[i].clear, tbl[i].ar, tbl[i].limit);
            check($sformatf("tbl[%0d].count", i), o_count, tbl[i].e_count);
            check($sformatf("tbl[%0d].tick", i),  o_tick,  tbl[i].e_tick);
            check($sformatf("tbl[%0d].busy", i),  o_busy,  tbl[i].e_busy);
            check($sformatf("tbl[%0d].done", i),  o_done,  tbl[i].e_done);
            check($sformatf("tbl[%0d].state", i), o_state, tbl[i].e_state);
        end

        // Auto-reload with limit=2 over three full count cycles, started from DONE.
        cyc(1, 0, 0, 1, N'(2));
        n_tick = 0;
        n_done = 0;
        n_seen = 0;
        for (int j = 1; j <= 25; j++) begin
            cyc(0, 0, 0, 1, N'(2));
            if (o_tick) n_tick++;
            if (o_done) n_done++;
            if (j > 1 && j % T == 1) begin
                check($sformatf("reload.count_after_tick%0d", n_seen), o_count, (n_seen % 2 == 0) ? 1 : 0);
                n_seen++;
            end
        end
        check("reload.ticks", n_tick, 6);
        check("reload.dones", n_done, 3);
        check("reload.state", o_state, RUN);
        cyc(0, 0, 1, 0, '0);

        // Pause for five cycles when pre==1 and count==1.
        cyc(1, 0, 0, 0, N'(9));
        for (int j = 1; j <= 6; j++) cyc(0, 0, 0, 0, N'(9));
        cyc(0, 1, 0, 0, N'(9));
        check("pause.entry_tick", o_tick, 0);
        check("pause.entry_count", o_count, 1);
        for (int j = 0; j < 4; j++) begin
            cyc(0, 1, 0, 0, N'(9));
            check("pause.held_state", o_state, PAUSED);
            check("pause.held_tick", o_tick, 0);
            check("pause.held_count", o_count, 1);
        end
        cyc(0, 0, 0, 0, N'(9));
        check("pause.release_state", o_state, PAUSED);
        cyc(0, 0, 0, 0, N'(9));
        check("pause.resume_tick0", o_tick, 0);
        cyc(0, 0, 0, 0, N'(9));
        check("pause.resume_tick1", o_tick, 1);
        cyc(0, 0, 0, 0, N'(9));
        check("pause.resume_count", o_count, 2);
        cyc(0, 0, 1, 0, '0);

        // Pause coincident with a tick.
        cyc(1, 0, 0, 0, N'(9));
        for (int j = 1; j <= 3; j++) cyc(0, 0, 0, 0, N'(9));
        cyc(0, 1, 0, 0, N'(9));
        check("pausetick.suppressed", o_tick, 0);
        cyc(0, 0, 0, 0, N'(9));
        check("pausetick.paused_state", o_state, PAUSED);
        check("pausetick.count_held", o_count, 0);
        cyc(0, 0, 0, 0, N'(9));
        check("pausetick.fires", o_tick, 1);
        cyc(0, 0, 0, 0, N'(9));
        check("pausetick.count", o_count, 1);
        cyc(0, 0, 1, 0, '0);

        // Clear with start held high at count 2.
        cyc(1, 0, 0, 0, N'(9));
        for (int j = 1; j <= 8; j++) cyc(0, 0, 0, 0, N'(9));
        cyc(1, 0, 1, 0, N'(9));
        check("clear.pre_count", o_count, 2);
        cyc(1, 0, 1, 0, N'(9));
        check("clear.state", o_state, IDLE);
        check("clear.count", o_count, 0);
        check("clear.no_done", o_done, 0);
        cyc(0, 0, 0, 0, N'(9));
        check("clear.start_ignored", o_state, IDLE);

        // Start with limit 0: immediate DONE, one done pulse, no ticks.
        cyc(1, 0, 0, 0, '0);
        n_tick = 0;
        n_done = 0;
        for (int j = 1; j <= 5; j++) begin
            cyc(0, 0, 0, 0, '0);
            if (o_tick) n_tick++;
            if (o_done) n_done++;
            check("zero.state", o_state, DONE);
        end
        check("zero.ticks", n_tick, 0);
        check("zero.dones", n_done, 1);

        // Asynchronous reset during a done pulse of a reloading run.
        cyc(1, 0, 0, 1, N'(1));
        for (int j = 1; j <= 4; j++) cyc(0, 0, 0, 1, N'(1));
        #1;
        check("rst.done_before", done, 1);
        do_reset("rst_mid_run");

        // Randomized traffic against the model.
        pause_left = 0;
        for (int k = 0; k < 2500; k++) begin
            logic         rs;
            logic         rp;
            logic         rc;
            logic         rar;
            logic [N-1:0] rl;
            if ($urandom_range(0, 399) == 0) do_reset("rand_rst");
            if (pause_left == 0 && $urandom_range(0, 9) == 0) pause_left = $urandom_range(1, 6);
            rp = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            rc  = ($urandom_range(0, 59) == 0);
            rs  = ($urandom_range(0, 3) == 0);
            rar = 1'($urandom_range(0, 1));
            rl  = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom_range(0, 6));
            cyc(rs, rp, rc, rar, rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_counter_ctrl.md
# slow_counter_ctrl

Sequencing controller for the lab's slow (prescaled) counters. It owns an internal clock-enable prescaler and an N-bit event counter. It runs the counter from a start command up to a programmable limit, with pause/resume, synchronous clear and optional auto-reload. It sits between the button/switch debouncers and the display/LED logic, replacing free-running slow counters wherever a bounded, restartable count is needed.

## Interface
- TICK_CYCLES, 5000: clk cycles per count tick; legal range 1 to 2^26-1.
- N, 4: counter and limit width.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  level-sampled command; acted on only in IDLE or DONE.
- pause  in  1  level; while high in RUN/PAUSED, counting is frozen.
- clear  in  1  synchronous abort to IDLE; highest priority.
- auto_reload  in  1  sampled every terminal event; 1 = wrap to 0 and keep running.
- limit  in  N  terminal count; captured into limit_q when start is accepted.
- count  out  N  current count, registered.
- tick  out  1  one-cycle pulse per counted tick, combinational from registered state.
- busy  out  1  high in RUN or PAUSED.
- done  out  1  one-cycle registered pulse on each terminal event.
- state  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.

## Operation
- Prescaler: 26-bit down-counter pre.
  - Loaded with TICK_CYCLES-1 on reset, on clear, and on any entry to RUN from IDLE or DONE.
  - In RUN with pause low: at 0, reloads TICK_CYCLES-1; otherwise decrements.
  - Frozen in PAUSED, so a partial period is preserved.
- Internal tick: tick = (state==RUN) && (pre==0) && !pause && !clear.
- Priority each cycle: clear > pause > tick > start.
- IDLE: count=0.
  - start → capture limit_q=limit.
  - If limit==0: go to DONE, done=1 next cycle.
  - Otherwise: go to RUN.
- RUN:
  - pause=1 → PAUSED; a coincident tick is suppressed and pre stays 0.
  - On tick, nxt=count+1 (N-bit).
  - If nxt==limit_q and auto_reload=1: count←0, done pulse, stay in RUN.
  - If nxt==limit_q and auto_reload=0: count←limit_q, done pulse, go to DONE.
  - Otherwise: count←nxt.
- PAUSED: count and pre held. pause=0 → RUN. start is ignored.
- DONE: count holds limit_q. start → recapture limit and clear count to 0, then apply the same limit==0 rule as IDLE.
- clear (any state): state←IDLE, count←0, pre←TICK_CYCLES-1, done←0. No done pulse.
- start while RUN/PAUSED: ignored; limit changes mid-run are ignored.
- Count never wraps past limit_q. With limit_q = 2^N-1, the terminal event occurs at count 2^N-1.

## Timing
- Reset values: count=0, tick=0, busy=0, done=0, state=IDLE, pre=TICK_CYCLES-1, limit_q=0. Reset takes effect immediately, without a clock edge, from any state, including mid-period or during a done pulse.
- Start accepted at edge k:
  - state=RUN from k.
  - First tick is high during the cycle after edge k+TICK_CYCLES-1.
  - count updates at the following edge.
  - Terminal count L reached L*TICK_CYCLES edges after start.
- done is high for exactly the one cycle following the terminal tick edge, coincident with the first cycle of count=limit_q (or count=0 under reload).
- Pause latency: pause high at edge j freezes at edge j; counting resumes with pre unchanged on the edge after pause falls.
- busy and state change on the same edge as the state register.

## Test plan
- TICK_CYCLES=4, N=4, limit=3, auto_reload=0:
  - Reset, pulse start for 1 cycle.
  - Required: tick every 4 cycles; count 1,2,3; done once on the cycle count becomes 3; state=DONE; busy falls.
- limit=2, auto_reload=1, run 3 periods.
  - Required: count sequence 1,0,1,0,1,0; done pulses every 8 cycles; state stays RUN.
- pause asserted for 5 cycles when pre==1 and count=1.
  - Required: state=PAUSED; no tick; count=1.
  - After release: tick after 2 more cycles; count=2.
- pause and tick in the same cycle: tick suppressed, count unchanged. First RUN cycle after release: tick fires.
- clear asserted in RUN at count=2, with clear and start both high.
  - Required: next cycle state=IDLE, count=0, no done.
  - start then ignored while clear is high.
- start with limit=0: DONE with a single done pulse and no ticks. Also, rst low mid-RUN gives an immediate return to all reset values.
